conv_host_mem: RTL
==================

Name: conv_host_mem

Overview:
- Memory-side responder for the CONV accelerator interface: holds the 64x64 image, layer-0 (4096x20) and layer-1 (1024x20) result memories.
- Services iaddr/idata reads, and cwr/crd/csel layer-memory traffic.
- Runs the ready/busy start handshake; exposes a dump port for post-run readback.
- Sits between the system loader/checker and the accelerator core.

Parameters:
- TIMEOUT, 16, max cycles ready is held waiting for busy to rise.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request one accelerator run
- img_we  in  1  image write strobe from loader
- img_waddr  in  12  image write address {row,col}
- img_wdata  in  20  image pixel, signed
- ready  out  1  start request to accelerator
- busy  in  1  accelerator busy
- iaddr  in  12  image read address
- idata  out  20  image read data
- cwr  in  1  layer write enable
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  12  layer read address
- cdata_rd  out  20  layer read data
- csel  in  3  layer select: 001 = L0, 011 = L1
- done  out  1  one-cycle pulse at run completion
- err  out  2  sticky: [0] illegal csel on cwr/crd, [1] handshake timeout
- l0_wr_cnt  out  13  L0 writes this run
- l1_wr_cnt  out  11  L1 writes this run
- dump_sel  in  1  0 = L0, 1 = L1
- dump_addr  in  12  dump address (L1 uses [9:0])
- dump_data  out  20  dump read data

Behaviour:
- Reset values: ready=0, done=0, err=0, both counters 0, state IDLE. Memory arrays are not cleared.
- Reset mid-operation returns to IDLE immediately and drops ready. Memory contents are retained.
- States: IDLE, HANDSHAKE, RUN, DONE.
- IDLE: start=1 -> HANDSHAKE. On that edge ready<=1, timeout counter<=0, l0/l1 counts<=0.
- HANDSHAKE: ready=1 each cycle.
  - busy sampled 1 -> RUN, ready<=0.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with busy still 0 -> IDLE, ready<=0, err[1]<=1.
  - Ready is held at most TIMEOUT cycles.
- RUN: busy sampled 0 -> DONE, done=1 for exactly that next cycle.
- DONE: start=1 -> HANDSHAKE, with the same actions as from IDLE.
- img_we is honoured only in IDLE and DONE: mem_img[img_waddr]<=img_wdata at the edge. Ignored in HANDSHAKE and RUN.
- idata = mem_img[iaddr], combinational (asynchronous read), valid in every state.
- Layer write, at the edge when cwr=1 in any state:
  - csel=001: L0[caddr_wr]<=cdata_wr; l0_wr_cnt increments.
  - csel=011: L1[caddr_wr[9:0]]<=cdata_wr; l1_wr_cnt increments.
  - Any other csel: no write, err[0]<=1.
- Counters saturate at all-ones; they do not wrap.
- Layer read, combinational:
  - crd=1, csel=001: cdata_rd=L0[caddr_rd].
  - crd=1, csel=011: cdata_rd=L1[caddr_rd[9:0]].
  - crd=0: cdata_rd=0.
  - crd=1 with illegal csel: cdata_rd=0, err[0]<=1 at the edge.
- cwr=1 and crd=1 together: legal. A read of the address being written returns the old contents that cycle; the new value is visible the next cycle.
- dump_data = L0[dump_addr] or L1[dump_addr[9:0]] per dump_sel, combinational, in all states.
- err clears only on reset.
- start while in HANDSHAKE or RUN is ignored.

Test Plan:
- Handshake: load image with mem_img[a]=a, pulse start, drive busy=1 two cycles after ready rises. Expect ready high for exactly 2 cycles then 0, state RUN. Drop busy 100 cycles later -> done pulses once.
- Image read: in RUN, iaddr=0x041 -> idata=0x00041 same cycle. img_we to 0x041 with 0xFFFFF during RUN -> idata still 0x00041.
- Layer traffic:
  - cwr, csel=001, caddr_wr=0xABC, cdata_wr=0x12345, then crd with caddr_rd=0xABC -> cdata_rd=0x12345, l0_wr_cnt=1.
  - csel=011, caddr_wr=0xC05 -> stored at L1[0x005]; dump_sel=1, dump_addr=0x005 returns it.
- Same-cycle read/write: L0[0x010]=0x00001; cwr writes 0x00002 to 0x010 while crd reads 0x010 -> cdata_rd=0x00001 that cycle, 0x00002 next cycle.
- Errors: cwr with csel=010 -> no memory change, err=01. Start with busy held 0 -> ready high 16 cycles, then 0, err[1]=1, state IDLE.
- Full run: 4096 L0 writes and 1024 L1 writes -> l0_wr_cnt=4096, l1_wr_cnt=1024. Assert reset mid-RUN -> ready=0, counters 0, memory contents retained.

Source files
------------

// File: rtl/conv_host_mem.sv
// conv_host_mem: memory-side responder for the CONV accelerator (image, L0/L1 result memories,
// ready/busy start handshake, layer traffic, post-run dump port).
`timescale 1ns/1ps
module conv_host_mem #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        img_we,
    input  logic [11:0] img_waddr,
    input  logic [19:0] img_wdata,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [19:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [19:0] cdata_rd,
    input  logic [2:0]  csel,
    output logic        done,
    output logic [1:0]  err,
    output logic [12:0] l0_wr_cnt,
    output logic [10:0] l1_wr_cnt,
    input  logic        dump_sel,
    input  logic [11:0] dump_addr,
    output logic [19:0] dump_data
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, HANDSHAKE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [19:0] mem_img [4096];
    logic [19:0] mem_l0 [4096];
    logic [19:0] mem_l1 [1024];
    logic [TW-1:0] tcnt;
    logic l0_sel, l1_sel, launch, idle_like, expire;
    assign l0_sel    = csel == 3'b001;
    assign l1_sel    = csel == 3'b011;
    assign idle_like = state == IDLE || state == DONE;
    assign launch    = idle_like && start;
    assign expire    = state == HANDSHAKE && !busy && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (launch) state_nxt = HANDSHAKE;
        else if (state == HANDSHAKE) state_nxt = busy ? RUN : expire ? IDLE : HANDSHAKE;
        else if (state == RUN && !busy) state_nxt = DONE;
    end
    assign ready = state == HANDSHAKE;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tcnt      <= '0;
            done      <= 1'b0;
            err       <= 2'b00;
            l0_wr_cnt <= '0;
            l1_wr_cnt <= '0;
        end else begin
            tcnt      <= launch ? '0 : state == HANDSHAKE ? tcnt + 1'b1 : tcnt;
            done      <= state == RUN && !busy;
            if (expire) err[1] <= 1'b1;
            if ((cwr || crd) && !l0_sel && !l1_sel) err[0] <= 1'b1;
            // counters hold at all-ones instead of wrapping
            l0_wr_cnt <= launch ? '0 : l0_wr_cnt + {12'd0, cwr && l0_sel && !(&l0_wr_cnt)};
            l1_wr_cnt <= launch ? '0 : l1_wr_cnt + {10'd0, cwr && l1_sel && !(&l1_wr_cnt)};
        end
    always_ff @(posedge clk) begin
        if (img_we && idle_like) mem_img[img_waddr] <= img_wdata;
        if (cwr && l0_sel) mem_l0[caddr_wr] <= cdata_wr;
        if (cwr && l1_sel) mem_l1[caddr_wr[9:0]] <= cdata_wr;
    end
    assign idata     = mem_img[iaddr];
    assign cdata_rd  = !crd ? '0 : l0_sel ? mem_l0[caddr_rd] : l1_sel ? mem_l1[caddr_rd[9:0]] : '0;
    assign dump_data = dump_sel ? mem_l1[dump_addr[9:0]] : mem_l0[dump_addr];
endmodule
